// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared decode, FSM state and ALU op definitions
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD_RD, S_LOAD_WR, S_STORE,
    S_ALU_RD, S_ALU_WR, S_BRANCH, S_NEXT, S_HALT
  } ctrl_state_type;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  // MOVE is realised as OR of the source with itself
  function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
    case (instr)
      I_AND:         return OP_AND;
      I_OR, I_MOVE:  return OP_OR;
      I_SUB:         return OP_SUB;
      default:       return OP_ADD;
    endcase
  endfunction

  function automatic logic branch_taken(input decoded_instruction_type instr,
                                        input logic zero, input logic neg,
                                        input logic u_ov, input logic s_ov);
    case (instr)
      I_BRANCH: return 1'b1;
      I_BZERO:  return zero;
      I_BNZERO: return !zero;
      I_BNEG:   return neg;
      I_BNNEG:  return !neg;
      I_BOV:    return u_ov | s_ov;
      I_BNOV:   return !(u_ov | s_ov);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control unit to data path strobe and status bundle
interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic       zero_op;
  logic       neg_op;
  logic       unsigned_overflow;
  logic       signed_overflow;
  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       write_reg_enable;
  logic       flags_reg_enable;
  logic       ram_write_enable;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable
  );

endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore instruction-sequencing FSM with retired-instruction counter
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  control_unit_if.master     cif,
  output logic               halt,
  output logic [COUNT_W-1:0] instr_count
);

  ctrl_state_type     state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               retire;

  always_comb begin
    state_d              = state_q;
    retire               = 1'b0;
    cif.branch           = 1'b0;
    cif.pc_enable        = 1'b0;
    cif.ir_enable        = 1'b0;
    cif.addr_sel         = 1'b0;
    cif.c_sel            = 1'b0;
    cif.operation        = OP_ADD;
    cif.write_reg_enable = 1'b0;
    cif.flags_reg_enable = 1'b0;
    cif.ram_write_enable = 1'b0;
    halt                 = 1'b0;

    case (state_q)
      S_FETCH: begin
        cif.ir_enable = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        case (cif.decoded_instruction)
          I_LOAD:                            state_d = S_LOAD_RD;
          I_STORE:                           state_d = S_STORE;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR: state_d = S_ALU_RD;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:            state_d = S_BRANCH;
          I_HALT:                            state_d = S_HALT;
          default:                           state_d = S_NEXT;
        endcase
      end
      S_LOAD_RD: begin
        cif.addr_sel = 1'b1;
        state_d      = S_LOAD_WR;
      end
      S_LOAD_WR: begin
        cif.addr_sel         = 1'b1;
        cif.c_sel            = 1'b1;
        cif.write_reg_enable = 1'b1;
        state_d              = S_NEXT;
      end
      S_STORE: begin
        cif.addr_sel         = 1'b1;
        cif.ram_write_enable = 1'b1;
        state_d              = S_NEXT;
      end
      S_ALU_RD: begin
        cif.operation = alu_op(cif.decoded_instruction);
        state_d       = S_ALU_WR;
      end
      S_ALU_WR: begin
        cif.operation        = alu_op(cif.decoded_instruction);
        cif.write_reg_enable = 1'b1;
        cif.flags_reg_enable = (cif.decoded_instruction != I_MOVE);
        state_d              = S_NEXT;
      end
      S_BRANCH: begin
        if (branch_taken(cif.decoded_instruction, cif.zero_op, cif.neg_op,
                         cif.unsigned_overflow, cif.signed_overflow)) begin
          cif.pc_enable = 1'b1;
          cif.branch    = 1'b1;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        cif.pc_enable = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_HALT: halt = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every strobe of the cycle so an abandoned instruction writes nothing
    if (rst) begin
      retire               = 1'b0;
      cif.branch           = 1'b0;
      cif.pc_enable        = 1'b0;
      cif.ir_enable        = 1'b0;
      cif.addr_sel         = 1'b0;
      cif.c_sel            = 1'b0;
      cif.operation        = OP_ADD;
      cif.write_reg_enable = 1'b0;
      cif.flags_reg_enable = 1'b0;
      cif.ram_write_enable = 1'b0;
      halt                 = 1'b0;
    end
  end

  assign count_d     = count_q + COUNT_W'(retire);
  assign instr_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style instruction-sequencing FSM for the K&S 16-bit processor. It sits directly upstream of the data path and drives every data-path control strobe. It sequences fetch, decode and execute for each instruction, using the data path's decoded instruction and registered flags. It also drives the RAM write strobe, a halt indication and a retired-instruction counter.

## Interface
Parameters:
- `COUNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `decoded_instruction` input `decoded_instruction_type`: current IR decode from the data path.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow` input 1 each: registered flags from the data path.
- `branch` output 1: PC load select (1 = mem_addr, 0 = PC+1).
- `pc_enable` output 1: PC update strobe.
- `ir_enable` output 1: IR load strobe.
- `addr_sel` output 1: RAM address select (0 = PC, 1 = mem_addr).
- `c_sel` output 1: register write source (1 = data_in, 0 = ALU).
- `operation` output 2: ALU op (00 add, 01 and, 10 or, 11 sub).
- `write_reg_enable` output 1: register-file write strobe.
- `flags_reg_enable` output 1: flag register load strobe.
- `ram_write_enable` output 1: RAM write strobe.
- `halt` output 1: processor stopped.
- `instr_count` output `COUNT_W`: retired-instruction count.

## Operation
- States: `S_FETCH`, `S_DECODE`, `S_LOAD_RD`, `S_LOAD_WR`, `S_STORE`, `S_ALU_RD`, `S_ALU_WR`, `S_BRANCH`, `S_NEXT`, `S_HALT`.

`S_FETCH`:
- Outputs: `addr_sel`=0, `ir_enable`=1.
- Next state: `S_DECODE`.

`S_DECODE`: all strobes 0. Dispatch on `decoded_instruction`:
- I_LOAD → `S_LOAD_RD`.
- I_STORE → `S_STORE`.
- I_MOVE, I_ADD, I_SUB, I_AND, I_OR → `S_ALU_RD`.
- Any branch → `S_BRANCH`.
- I_HALT → `S_HALT`.
- I_NOP or any other value → `S_NEXT`.

`S_LOAD_RD`:
- Outputs: `addr_sel`=1 (covers the one-cycle RAM read latency).
- Next state: `S_LOAD_WR`.

`S_LOAD_WR`:
- Outputs: `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1.
- Next state: `S_NEXT`.

`S_STORE`:
- Outputs: `addr_sel`=1, `ram_write_enable`=1.
- Next state: `S_NEXT`.

`S_ALU_RD`:
- Outputs: `operation` driven per instruction; no strobes. This is the operand-settle cycle.
- Next state: `S_ALU_WR`.

`S_ALU_WR`:
- Outputs: same `operation`, `c_sel`=0, `write_reg_enable`=1.
- `flags_reg_enable`=1 for ADD, SUB, AND and OR; 0 for MOVE.
- Next state: `S_NEXT`.

Operation mapping:
- ADD → 00.
- AND → 01.
- OR → 10.
- SUB → 11.
- MOVE → 10 (OR of the source with itself).

`S_BRANCH`: the branch is taken when the condition below holds.
- BRANCH: always.
- BZERO: `zero_op`.
- BNZERO: `!zero_op`.
- BNEG: `neg_op`.
- BNNEG: `!neg_op`.
- BOV: `unsigned_overflow | signed_overflow`.
- BNOV: both overflow flags 0.

Branch outcome:
- Taken: `pc_enable`=1, `branch`=1; next state `S_FETCH`; the instruction retires.
- Not taken: no strobes; next state `S_NEXT`.

`S_NEXT`:
- Outputs: `pc_enable`=1, `branch`=0.
- Next state: `S_FETCH`; the instruction retires.

`S_HALT`:
- Outputs: `halt`=1, all strobes 0.
- Remains in `S_HALT` until `rst`. HALT itself does not retire.

Retirement and counter:
- `instr_count` increments by 1 on each retire edge.
- It wraps modulo 2^`COUNT_W`; it does not saturate.
- Flags are sampled only in `S_BRANCH`; they are ignored elsewhere.

## Timing
- Reset:
  - `rst`=1 at a rising edge sets the state to `S_FETCH` and `instr_count` to 0.
  - While `rst` is high, all outputs are forced to 0 (`halt`=0, `operation`=00).
  - The first cycle after release is `S_FETCH`.
- Reset mid-instruction:
  - The instruction is abandoned with no partial write; any strobe of that cycle is suppressed.
  - Reset overrides `S_HALT`.
  - The top level drives the data-path PC reset from the same `rst`.
- Outputs are purely decoded from the state register plus the registered IR decode. There is no combinational path from flags to outputs except in `S_BRANCH`.
- Cycles per instruction, from FETCH to the next FETCH:
  - NOP: 3.
  - STORE: 4.
  - LOAD: 5.
  - ALU/MOVE: 5.
  - Taken branch: 3.
  - Untaken branch: 4.
- Flag hazard: flags written in `S_ALU_WR` are visible to a branch that immediately follows, because at least 3 edges separate the two.
- Strobe exclusivity: at most one of `write_reg_enable`, `ram_write_enable`, `ir_enable` is high in any cycle; a bench assertion checks this.

## Structure
- `k_and_s_pkg`:
  - Holds `decoded_instruction_type` (already shared with the data path).
  - Add an enum `ctrl_state_type` for the FSM states.
  - Add a constant set for the ALU op codes (`OP_ADD`, `OP_AND`, `OP_OR`, `OP_SUB`), shared with the data path ALU.
- No sub-module: one state register, one next-state/output `always_comb`, and one counter process.
- A `cpu_top` wrapper instantiates `control_unit`, `data_path` and RAM and handles the reset polarity adaptation. It is outside this block.

## Test plan
- Reset, then run NOP: `ir_enable` is high in cycle 0, `pc_enable` is high in cycle 2, back to FETCH in cycle 3, `instr_count`=1.
- ADD: `operation`=00 in both execute cycles; `write_reg_enable` and `flags_reg_enable` are high only in the 4th cycle; 5 cycles total.
- MOVE: `operation`=10, `write_reg_enable` pulses once, `flags_reg_enable` stays 0 throughout.
- LOAD then STORE: `addr_sel`=1 across 2 cycles with `c_sel`=1 on the write; STORE gives `ram_write_enable` exactly 1 cycle; counts 5 and 4 cycles.
- BZERO with `zero_op`=1: `branch`=1 and `pc_enable`=1 in cycle 2. With `zero_op`=0: no `branch`, `pc_enable` in cycle 3. Repeat for BNZERO, BNEG, BNNEG, BOV and BNOV with both flag polarities.
- HALT then hold 10 cycles: `halt`=1, no strobes, `instr_count` frozen; assert `rst` in `S_LOAD_RD`: no register write, next state `S_FETCH`, count 0. Preload `instr_count` to 0xFFFF, retire 1: count 0x0000.
